// File: rtl/irq_ctrl_sv.sv
// irq_ctrl_sv: AXI4-Lite interrupt controller merging NUM_SOURCES lines into one registered irq.
// Optional IRQ_EDGE_EN selects rising-edge capture instead of level-sensitive pending bits.
module irq_ctrl_sv #(
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_SOURCES = 4
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [1:0]                    s_axi_bresp,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic [NUM_SOURCES-1:0]        irq_src,
  output logic                          irq
);
  localparam logic [31:0] SRC_MASK = 32'hFFFF_FFFF >> (32 - NUM_SOURCES);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [31:0] isr, ier, ipr, ivr, rd_val, bmask, wr_val, set, clr;
  logic [2:0] waddr, raddr;
  logic mer, wr_en, rd_en;
  logic unused_ok;
`ifdef IRQ_EDGE_EN
  logic [NUM_SOURCES-1:0] src_q;
  assign set = 32'(irq_src & ~src_q);
`else
  assign set = 32'(irq_src);
`endif
  assign waddr = s_axi_awaddr[4:2];
  assign raddr = s_axi_araddr[4:2];
  assign bmask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign wr_val = s_axi_wdata & bmask;
  assign ipr = isr & ier;
  assign s_axi_awready = wr_en;
  assign s_axi_wready = wr_en;
  assign s_axi_arready = rd_en;
  assign s_axi_bvalid = w_state == W_RESP;
  assign s_axi_rvalid = r_state == R_DATA;
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};
  always_comb begin
    wr_en = (w_state == W_IDLE) & s_axi_awvalid & s_axi_wvalid & ~s_axi_areset;
    rd_en = (r_state == R_IDLE) & s_axi_arvalid & ~s_axi_areset;
    w_next = wr_en ? W_RESP : (w_state == W_RESP && s_axi_bready) ? W_IDLE : w_state;
    r_next = rd_en ? R_DATA : (r_state == R_DATA && s_axi_rready) ? R_IDLE : r_state;
    clr = (wr_en && waddr == 3'd2) ? wr_val & SRC_MASK : '0;
    ivr = '1;
    for (int i = NUM_SOURCES - 1; i >= 0; i--)
      if (ipr[i]) ivr = 32'(i);
    rd_val = raddr == 3'd0 ? isr :
             raddr == 3'd1 ? ier :
             raddr == 3'd3 ? {31'b0, mer} :
             raddr == 3'd4 ? ipr :
             raddr == 3'd5 ? ivr : '0;
  end
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      isr <= '0;
      ier <= '0;
      mer <= 1'b0;
      irq <= 1'b0;
      s_axi_rdata <= '0;
`ifdef IRQ_EDGE_EN
      src_q <= '0;
`endif
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      // set is ORed after the clear so a same-cycle set wins
      isr <= (isr & ~clr) | set;
      if (wr_en && waddr == 3'd1) ier <= ((ier & ~bmask) | wr_val) & SRC_MASK;
      if (wr_en && waddr == 3'd3 && s_axi_wstrb[0]) mer <= s_axi_wdata[0];
      irq <= mer & |ipr;
      if (rd_en) s_axi_rdata <= rd_val;
`ifdef IRQ_EDGE_EN
      src_q <= irq_src;
`endif
    end
  end
endmodule

// File: doc/irq_ctrl_sv.md
# irq_ctrl_sv

Memory-mapped AXI4-Lite interrupt controller. Collects the interrupt lines of the system's peripheral timers and I/O blocks (e.g. the PIT `irq`) into one processor interrupt. Software can enable, inspect, prioritise and acknowledge each source. Sits on the same AXI-Lite interconnect as its sources and drives the CPU's interrupt input.

## Interface
- `C_S_AXI_ADDR_WIDTH`, default 5: width of the S_AXI address bus.
- `NUM_SOURCES`, default 4: number of interrupt inputs, legal range 1..32.

Ports:
- `s_axi_aclk` in 1: clock; all logic is on its rising edge.
- `s_axi_areset` in 1: reset, synchronous, active-high.
- `s_axi_awvalid` in 1 / `s_axi_awready` out 1 / `s_axi_awaddr` in C_S_AXI_ADDR_WIDTH / `s_axi_awprot` in 3 (ignored): write address channel.
- `s_axi_wvalid` in 1 / `s_axi_wready` out 1 / `s_axi_wdata` in 32 / `s_axi_wstrb` in 4: write data channel.
- `s_axi_bvalid` out 1 / `s_axi_bready` in 1 / `s_axi_bresp` out 2: write response channel.
- `s_axi_arvalid` in 1 / `s_axi_arready` out 1 / `s_axi_araddr` in C_S_AXI_ADDR_WIDTH / `s_axi_arprot` in 3 (ignored): read address channel.
- `s_axi_rdata` out 32 / `s_axi_rresp` out 2 / `s_axi_rvalid` out 1 / `s_axi_rready` in 1: read data channel.
- `irq_src` in NUM_SOURCES: peripheral interrupt lines, synchronous to `s_axi_aclk`.
- `irq` out 1: combined interrupt to the processor.

## Operation
- Register map (word offsets, `addr[4:2]`; `addr[1:0]` ignored):
  - 0x00 ISR, RO: pending bits.
  - 0x04 IER, RW: per-source enable.
  - 0x08 IAR, WO: writing 1 clears the matching ISR bit. Reads return 0.
  - 0x0C MER, RW: bit0 is the master enable; other bits read 0.
  - 0x10 IPR, RO: ISR & IER.
  - 0x14 IVR, RO: index of the lowest-numbered set IPR bit; 0xFFFFFFFF if none.
  - 0x18–0x1C: unmapped. Reads return 0; writes are ignored.
- Bits at or above NUM_SOURCES in ISR/IER/IAR/IPR: read 0, writes ignored.
- Writes honour `s_axi_wstrb` per byte for IER, IAR and MER.
- Pending set: see Configuration. A pending bit stays set until acknowledged through IAR.
- Set and IAR clear on the same bit in the same cycle: set wins, and the bit remains 1.
- `irq` is registered: `irq <= MER[0] & |(ISR & IER)`.
- Disabling a source in IER does not clear its ISR bit.
- `s_axi_bresp` and `s_axi_rresp` are always 2'b00 (OKAY).

## Timing
- Reset values: ISR, IER and MER are 0. `irq`, `s_axi_awready`, `s_axi_wready`, `s_axi_bvalid`, `s_axi_arready` and `s_axi_rvalid` are 0. `s_axi_rdata` is 0.
- Write FSM, states IDLE → RESP:
  - In IDLE, when `awvalid & wvalid` are both high, `awready` and `wready` pulse high together for 1 cycle and the register updates on that edge.
  - `bvalid` rises the next cycle and holds until `bready`, then returns to IDLE.
  - A lone AW or lone W is not accepted. The block waits for both.
- Read FSM, states IDLE → DATA:
  - In IDLE with `arvalid`, `arready` pulses for 1 cycle.
  - `rvalid` and `rdata` are registered the next cycle, and `rdata` holds stable until `rready`.
  - `rdata` captures the register value at the address-accept edge.
- Read and write channels are independent and may complete in the same cycle.
- Interrupt latency:
  - `irq_src` bit sampled high at edge k → ISR bit set at edge k → `irq` high at edge k+1.
  - An IAR write accepted at edge k clears the bit at k; `irq` falls at k+1 if no other enabled pending bit remains.
- Reset asserted mid-transaction aborts it: all valids and readies drop on the next edge and no response is issued.

## Configuration
- `IRQ_EDGE_EN`:
  - **Defined:** each source is registered (`src_q`, reset 0). The ISR bit is set only on a rising edge (`irq_src & ~src_q`). A source held high sets ISR once.
  - **Undefined:** level-sensitive. The ISR bit is set every cycle the source is high, so an IAR clear while the source is still high is immediately overridden (set wins).

## Test plan
- **Reset:** hold `s_axi_areset` 2 cycles, then read all six registers. Expect ISR=0, IER=0, MER=0, IPR=0, IVR=0xFFFFFFFF, `irq`=0, `bresp`/`rresp`=0.
- **Basic interrupt:** write IER=0x5, then MER=0x1. Pulse `irq_src`=4'b0100 for 1 cycle.
  - Expect ISR=0x4, IPR=0x4, IVR=2, and `irq` high exactly 1 cycle after ISR sets.
  - Then write IAR=0x4: expect ISR=0 and `irq` low 1 cycle later.
- **Masking and priority:** IER=0x2, pulse sources 0 and 3. Expect ISR=0x9, IPR=0, IVR=0xFFFFFFFF, `irq`=0.
  - Then write IER=0xF: expect IVR=0 and `irq`=1.
- **Set/clear collision:** an IAR write of 0x1 accepted in the same cycle that source 0 sets. Expect ISR[0]=1 afterwards.
- **Edge vs level:** hold `irq_src[1]` high for 10 cycles and write IAR=0x2 mid-hold.
  - With `IRQ_EDGE_EN`: ISR[1]=0 after the ack.
  - Without it: ISR[1]=1 after the ack.
- **Handshake:**
  - Present AW 3 cycles before W: `awready` and `wready` assert together only once W arrives.
  - Hold `bready`=0 for 5 cycles: `bvalid` stays high.
  - Issue a concurrent read to 0x04: it returns the pre-write IER value.
  - A write with `wstrb`=4'b0000 to IER leaves IER unchanged.
